// File: rtl/timer_bus_interface.sv
// 32-bit memory-mapped down-counting timer slave for the peripheral bus.
// Offers a prescaled timebase, one-shot or auto-reload counting and a
// registered level interrupt. Read data and wait-request are all-zero
// whenever the block is not selected, so they can be OR-combined with the
// other peripheral slaves.
//
// Bus handshake: a request (read or write) is presented while sel is true
// and completes in the first cycle in which o_AV_WaitRequest is 0. The
// master holds address/read/write stable while o_AV_WaitRequest is 1.
// Writes never stall. A read stalls for exactly one cycle (R_IDLE), and
// the data is valid in the following R_DATA cycle, where the read completes.
// A write presented together with a read wins; the read is not performed.
module timer_bus_interface #(
  parameter int NUM_PERIPH_SEL_BITS = 16,
  parameter logic [NUM_PERIPH_SEL_BITS-1:0] PERIPH_SEL_VAL = 16'hFC08,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        i_Clk,
  input  logic        i_nRst,
  input  logic [29:0] i_AV_Addr,
  input  logic [3:0]  i_AV_ByteEn,
  input  logic        i_AV_Read,
  output logic [31:0] o_AV_ReadData,
  input  logic        i_AV_Write,
  input  logic [31:0] i_AV_WriteData,
  output logic        o_AV_WaitRequest,
  input  logic [7:0]  i_AV_BurstCount,
  output logic        o_Irq
);

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_LOAD     = 3'd1;
  localparam logic [2:0] IDX_COUNT    = 3'd2;
  localparam logic [2:0] IDX_PRESCALE = 3'd3;
  localparam logic [2:0] IDX_STATUS   = 3'd4;

  localparam logic [PRESCALE_WIDTH-1:0] PSC_ONE = 1;

  // Decode
  logic       sel;
  logic [2:0] reg_idx;
  logic       wr_en;
  logic       rd_req;

  // Register state
  logic                      ctrl_en;
  logic                      ctrl_auto;
  logic                      ctrl_irq_en;
  logic [31:0]               load_q;
  logic [31:0]               count_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] psc_cnt_q;
  logic                      expired_q;
  logic                      irq_q;

  // Read path
  rd_state_t   rd_state;
  rd_state_t   rd_state_nxt;
  logic [31:0] rd_mux;
  logic [31:0] rd_data_q;

  // Timer control strobes
  logic                      ctrl_wr;
  logic                      load_wr;
  logic                      psc_wr;
  logic                      status_clr;
  logic                      en_start;
  logic                      en_stop;
  logic                      run;
  logic                      tick;
  logic                      expire;
  logic [31:0]               load_merged;
  logic [PRESCALE_WIDTH-1:0] prescale_merged;

  // Burst count and the address bits between the selector and the register
  // index play no part in decoding.
  logic unused_inputs;
  assign unused_inputs = ^{i_AV_BurstCount, i_AV_Addr};

  assign sel     = (i_AV_Addr[29 -: NUM_PERIPH_SEL_BITS] == PERIPH_SEL_VAL);
  assign reg_idx = i_AV_Addr[2:0];
  assign wr_en   = sel & i_AV_Write;
  assign rd_req  = sel & i_AV_Read & ~i_AV_Write;

  assign ctrl_wr    = wr_en & (reg_idx == IDX_CTRL) & i_AV_ByteEn[0];
  assign load_wr    = wr_en & (reg_idx == IDX_LOAD);
  assign psc_wr     = wr_en & (reg_idx == IDX_PRESCALE);
  assign status_clr = wr_en & (reg_idx == IDX_STATUS) & i_AV_ByteEn[0] &
                      i_AV_WriteData[0];

  // EN rising reloads the count; writing EN low freezes everything in place.
  assign en_start = ctrl_wr & i_AV_WriteData[0] & ~ctrl_en;
  assign en_stop  = ctrl_wr & ~i_AV_WriteData[0];
  assign run      = ctrl_en & ~en_stop;
  assign tick     = run & (psc_cnt_q == prescale_q);
  assign expire   = tick & (count_q == 32'd0);

  // Byte-lane merge of write data into LOAD and PRESCALE.
  always_comb begin
    load_merged     = load_q;
    prescale_merged = prescale_q;
    for (int b = 0; b < 4; b++) begin
      if (i_AV_ByteEn[b]) begin
        load_merged[8*b +: 8] = i_AV_WriteData[8*b +: 8];
      end
    end
    for (int i = 0; i < PRESCALE_WIDTH; i++) begin
      if (i_AV_ByteEn[i/8]) begin
        prescale_merged[i] = i_AV_WriteData[i];
      end
    end
  end

  // Software-visible configuration registers and the one-shot EN clear.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      ctrl_en     <= 1'b0;
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      load_q      <= '0;
      prescale_q  <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en     <= i_AV_WriteData[0];
        ctrl_auto   <= i_AV_WriteData[1];
        ctrl_irq_en <= i_AV_WriteData[2];
      end else if (expire && !ctrl_auto) begin
        ctrl_en <= 1'b0;
      end
      if (load_wr) begin
        load_q <= load_merged;
      end
      if (psc_wr) begin
        prescale_q <= prescale_merged;
      end
    end
  end

  // Prescaler and down-counter; reload on start or on auto-reload expiry.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      count_q   <= '0;
      psc_cnt_q <= '0;
    end else if (en_start) begin
      count_q   <= load_q;
      psc_cnt_q <= '0;
    end else if (run) begin
      if (tick) begin
        psc_cnt_q <= '0;
        if (count_q != 32'd0) begin
          count_q <= count_q - 32'd1;
        end else if (ctrl_auto) begin
          count_q <= load_q;
        end
      end else begin
        psc_cnt_q <= psc_cnt_q + PSC_ONE;
      end
    end
  end

  // Sticky expiry flag; a new expiry beats a simultaneous clear.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      expired_q <= 1'b0;
    end else if (expire) begin
      expired_q <= 1'b1;
    end else if (status_clr) begin
      expired_q <= 1'b0;
    end
  end

  // Registered level interrupt.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= expired_q & ctrl_irq_en;
    end
  end

  assign o_Irq = irq_q;

  // Register read multiplexer.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      IDX_CTRL:     rd_mux = {29'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
      IDX_LOAD:     rd_mux = load_q;
      IDX_COUNT:    rd_mux = count_q;
      IDX_PRESCALE: rd_mux = 32'(prescale_q);
      IDX_STATUS:   rd_mux = {31'd0, expired_q};
      default:      rd_mux = '0;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      rd_state <= R_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  // Read FSM next state: one stall cycle, then one data cycle.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (rd_req) rd_state_nxt = R_DATA;
      R_DATA:  rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Capture read data at the end of the stall cycle.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      rd_data_q <= '0;
    end else if (rd_state == R_IDLE && rd_req) begin
      rd_data_q <= rd_mux;
    end
  end

  // Read FSM outputs; reset forces both to zero without waiting for a clock.
  always_comb begin
    o_AV_WaitRequest = 1'b0;
    o_AV_ReadData    = '0;
    if (i_nRst) begin
      if (rd_state == R_IDLE && rd_req) begin
        o_AV_WaitRequest = 1'b1;
      end
      if (rd_state == R_DATA && sel) begin
        o_AV_ReadData = rd_data_q;
      end
    end
  end

endmodule

// File: tb/tb_timer_bus_interface.sv
// Directed testbench for timer_bus_interface: reset state, one-shot and
// auto-reload counting, byte-lane writes, status clear and reset mid-read.
module tb_timer_bus_interface;

  logic        clk;
  logic        rst_n;
  logic [29:0] addr;
  logic [3:0]  byte_en;
  logic        rd;
  logic [31:0] rd_data;
  logic        wr;
  logic [31:0] wr_data;
  logic        wait_req;
  logic [7:0]  burst;
  logic        irq;

  int n_vec;
  int n_err;

  timer_bus_interface dut (
    .i_Clk            (clk),
    .i_nRst           (rst_n),
    .i_AV_Addr        (addr),
    .i_AV_ByteEn      (byte_en),
    .i_AV_Read        (rd),
    .o_AV_ReadData    (rd_data),
    .i_AV_Write       (wr),
    .i_AV_WriteData   (wr_data),
    .o_AV_WaitRequest (wait_req),
    .i_AV_BurstCount  (burst),
    .o_Irq            (irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] reg_addr(input logic [2:0] idx);
    return {16'hFC08, 11'd0, idx};
  endfunction

  function automatic logic [29:0] other_addr(input logic [2:0] idx);
    return {16'hFC09, 11'd0, idx};
  endfunction

  // Driver: single-beat write, takes effect on the next rising edge.
  task automatic bus_write(input logic [2:0] idx, input logic [31:0] data,
                           input logic [3:0] be);
    @(negedge clk);
    addr    = reg_addr(idx);
    wr_data = data;
    byte_en = be;
    wr      = 1'b1;
    @(posedge clk);
    #1;
    wr      = 1'b0;
    byte_en = 4'h0;
  endtask

  // Driver: read with handshake shape reported (1 = stall then data).
  task automatic bus_read(input logic [2:0] idx, output logic [31:0] data,
                          output logic hs);
    logic w1;
    logic w2;
    @(negedge clk);
    addr = reg_addr(idx);
    rd   = 1'b1;
    #1;
    w1 = wait_req;
    @(negedge clk);
    w2   = wait_req;
    data = rd_data;
    rd   = 1'b0;
    hs   = (w1 === 1'b1) && (w2 === 1'b0);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        hs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({wait_req, rd_data, irq} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_outputs got wait=%b data=%h irq=%b exp 0", wait_req, rd_data, irq);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_read(3'(i), d, hs);
      n_vec++;
      if (hs !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read_handshake reg=%0d got %b exp 1", i, hs);
      end
      n_vec++;
      if (d !== 32'd0) begin
        n_err++;
        $display("FAIL reset_read_value reg=%0d got %h exp 00000000", i, d);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    logic        hs;
    bus_write(3'd1, 32'd3, 4'hF);
    bus_write(3'd3, 32'd0, 4'hF);
    bus_write(3'd0, 32'h5, 4'hF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (dut.count_q !== 32'(3 - k)) begin
        n_err++;
        $display("FAIL one_shot_count cycle=%0d got %h exp %h", k, dut.count_q, 32'(3 - k));
      end
    end
    @(negedge clk);
    n_vec++;
    if ({dut.expired_q, irq} !== 2'b10) begin
      n_err++;
      $display("FAIL one_shot_expire got expired=%b irq=%b exp expired=1 irq=0", dut.expired_q, irq);
    end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL one_shot_irq got %b exp 1", irq);
    end
    bus_read(3'd0, d, hs);
    n_vec++;
    if (d !== 32'h4) begin
      n_err++;
      $display("FAIL one_shot_ctrl got %h exp 00000004", d);
    end
    bus_read(3'd2, d, hs);
    n_vec++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL one_shot_count_hold got %h exp 00000000", d);
    end
    bus_write(3'd4, 32'h0, 4'hF);
    bus_write(3'd4, 32'h1, 4'h0);
    bus_read(3'd4, d, hs);
    n_vec++;
    if (d !== 32'h1) begin
      n_err++;
      $display("FAIL status_no_clear got %h exp 00000001", d);
    end
    bus_write(3'd4, 32'h1, 4'h1);
    bus_read(3'd4, d, hs);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL status_clear got %h exp 00000000", d);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL status_clear_irq got %b exp 0", irq);
    end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    logic [31:0] exp_cnt;
    logic        hs;
    bus_write(3'd1, 32'd2, 4'hF);
    bus_write(3'd3, 32'd4, 4'hF);
    bus_write(3'd0, 32'h3, 4'hF);
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      exp_cnt = 32'(2 - ((k % 15) / 5));
      n_vec++;
      if (dut.count_q !== exp_cnt) begin
        n_err++;
        $display("FAIL auto_count cycle=%0d got %h exp %h", k, dut.count_q, exp_cnt);
      end
      if (k == 14 || k == 21) begin
        n_vec++;
        if (dut.expired_q !== 1'b0) begin
          n_err++;
          $display("FAIL auto_expired_low cycle=%0d got %b exp 0", k, dut.expired_q);
        end
      end
      if (k == 15 || k == 30) begin
        n_vec++;
        if (dut.expired_q !== 1'b1) begin
          n_err++;
          $display("FAIL auto_expired_high cycle=%0d got %b exp 1", k, dut.expired_q);
        end
      end
      if (k == 20 || k == 29) begin
        addr    = reg_addr(3'd4);
        wr_data = 32'h1;
        byte_en = 4'hF;
        wr      = 1'b1;
      end
      if (k == 21 || k == 30) begin
        wr      = 1'b0;
        byte_en = 4'h0;
      end
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL auto_irq_masked got %b exp 0", irq);
    end
    bus_write(3'd0, 32'h0, 4'h1);
    repeat (10) @(negedge clk);
    bus_read(3'd2, d, hs);
    n_vec++;
    if (d !== 32'd2) begin
      n_err++;
      $display("FAIL stop_freeze_count got %h exp 00000002", d);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    logic        hs;
    bus_write(3'd1, 32'h0, 4'hF);
    bus_write(3'd1, 32'hAABBCCDD, 4'b0101);
    bus_read(3'd1, d, hs);
    n_vec++;
    if (d !== 32'h00BB00DD) begin
      n_err++;
      $display("FAIL load_byte_lanes got %h exp 00BB00DD", d);
    end
    bus_write(3'd2, 32'h12345678, 4'hF);
    bus_read(3'd2, d, hs);
    n_vec++;
    if (d !== 32'd2) begin
      n_err++;
      $display("FAIL count_write_ignored got %h exp 00000002", d);
    end
    bus_write(3'd0, 32'h7, 4'b1110);
    bus_read(3'd0, d, hs);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL ctrl_lane_masked got %h exp 00000000", d);
    end
    bus_write(3'd3, 32'hFFFFFFFF, 4'hF);
    bus_read(3'd3, d, hs);
    n_vec++;
    if (d !== 32'h0000FFFF) begin
      n_err++;
      $display("FAIL prescale_zero_ext got %h exp 0000FFFF", d);
    end
    bus_write(3'd5, 32'hFFFFFFFF, 4'hF);
    bus_read(3'd5, d, hs);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL reserved_reg got %h exp 00000000", d);
    end
    // Read and write together: write performed, no stall, no read data.
    @(negedge clk);
    addr    = reg_addr(3'd1);
    wr_data = 32'h11223344;
    byte_en = 4'hF;
    wr      = 1'b1;
    rd      = 1'b1;
    #1;
    n_vec++;
    if (wait_req !== 1'b0) begin
      n_err++;
      $display("FAIL rw_no_stall got %b exp 0", wait_req);
    end
    @(negedge clk);
    n_vec++;
    if (rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL rw_no_read_data got %h exp 00000000", rd_data);
    end
    wr      = 1'b0;
    rd      = 1'b0;
    byte_en = 4'h0;
    bus_read(3'd1, d, hs);
    n_vec++;
    if (d !== 32'h11223344) begin
      n_err++;
      $display("FAIL rw_write_done got %h exp 11223344", d);
    end
    // A read aimed at the other timer slot must leave both outputs at zero.
    @(negedge clk);
    addr = other_addr(3'd1);
    rd   = 1'b1;
    #1;
    n_vec++;
    if ({wait_req, rd_data} !== 33'd0) begin
      n_err++;
      $display("FAIL unselected_cycle0 got wait=%b data=%h exp 0", wait_req, rd_data);
    end
    @(negedge clk);
    n_vec++;
    if ({wait_req, rd_data} !== 33'd0) begin
      n_err++;
      $display("FAIL unselected_cycle1 got wait=%b data=%h exp 0", wait_req, rd_data);
    end
    rd = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic        hs;
    bus_write(3'd1, 32'h55, 4'hF);
    bus_write(3'd0, 32'h1, 4'hF);
    @(negedge clk);
    addr = reg_addr(3'd1);
    rd   = 1'b1;
    #1;
    n_vec++;
    if (wait_req !== 1'b1) begin
      n_err++;
      $display("FAIL midread_stall got %b exp 1", wait_req);
    end
    @(negedge clk);
    n_vec++;
    if (rd_data !== 32'h55) begin
      n_err++;
      $display("FAIL midread_data got %h exp 00000055", rd_data);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({wait_req, rd_data} !== 33'd0) begin
      n_err++;
      $display("FAIL midread_reset_outputs got wait=%b data=%h exp 0", wait_req, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd    = 1'b0;
    bus_read(3'd0, d, hs);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL post_reset_ctrl got %h exp 00000000", d);
    end
    repeat (5) @(negedge clk);
    bus_read(3'd2, d, hs);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL post_reset_count got %h exp 00000000", d);
    end
    n_vec++;
    if (hs !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_handshake got %b exp 1", hs);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    addr    = '0;
    byte_en = 4'h0;
    rd      = 1'b0;
    wr      = 1'b0;
    wr_data = '0;
    burst   = 8'd1;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_byte_lanes();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_bus_interface.md
Name: timer_bus_interface

Overview:
- Memory-mapped 32-bit down-counting timer slave on the peripheral bus, instantiated as TIMER0/TIMER1 in the small-peripheral block (selector values 10'd8 and 10'd9).
- Consumes the crossbar's peripheral output port: address, byte-enable, read, write, write-data and burst-count.
- Drives read-data and wait-request. Both are OR-combined with the other peripheral slaves, so both must be all-zero whenever the block is not selected.
- Provides a prescaled timebase, one-shot or auto-reload operation, and a level interrupt.

Parameters:
- NUM_PERIPH_SEL_BITS, 16, number of upper word-address bits compared for selection.
- PERIPH_SEL_VAL, 16'hFC08, value those bits must equal (default = TIMER0 slot).
- PRESCALE_WIDTH, 16, width of the prescaler register and counter.

Ports:
- i_Clk  in  1  system clock (75 MHz).
- i_nRst  in  1  reset; asynchronous, active-low.
- i_AV_Addr  in  30  word address.
- i_AV_ByteEn  in  4  write byte enables.
- i_AV_Read  in  1  read request.
- o_AV_ReadData  out  32  read data; 0 when not selected or not valid.
- i_AV_Write  in  1  write request.
- i_AV_WriteData  in  32  write data.
- o_AV_WaitRequest  out  1  stall; 0 when not selected.
- i_AV_BurstCount  in  8  ignored; only single beats are supported.
- o_Irq  out  1  interrupt, level, active-high.

Behaviour:
- Select: sel = (i_AV_Addr[29 -: NUM_PERIPH_SEL_BITS] == PERIPH_SEL_VAL). The register index is i_AV_Addr[2:0].
- Register map:
  - 0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; other bits read 0.
  - 1 LOAD: 32-bit reload value.
  - 2 COUNT: read-only current count; writes ignored.
  - 3 PRESCALE: PRESCALE_WIDTH bits, zero-extended on read.
  - 4 STATUS: [0] EXPIRED; write 1 to clear, write 0 has no effect.
  - 5–7: read 0, writes ignored.
- Writes:
  - Take effect on the clock edge where sel & i_AV_Write.
  - o_AV_WaitRequest stays 0, so every write completes in one cycle.
  - Each byte lane is written only when its i_AV_ByteEn bit is set; the same applies to STATUS and CTRL.
- Reads use a two-state FSM, R_IDLE / R_DATA:
  - R_IDLE with sel & i_AV_Read: o_AV_WaitRequest = 1 combinationally, register data is captured, then go to R_DATA.
  - R_DATA: o_AV_WaitRequest = 0 and o_AV_ReadData = captured value for exactly one cycle, then return to R_IDLE.
  - Read latency is therefore 1 wait cycle. In every other cycle o_AV_ReadData = 0.
  - Read and write asserted together: the write is performed and the read is ignored (no stall).
- Counting:
  - The prescaler counter runs only while EN = 1. When it equals PRESCALE it produces a tick and restarts at 0; PRESCALE = 0 gives a tick every cycle.
  - On a tick with COUNT != 0: COUNT decrements.
  - On a tick with COUNT == 0: EXPIRED is set. If AUTO_RELOAD = 1, COUNT ← LOAD. If AUTO_RELOAD = 0, COUNT stays 0 and EN clears to 0.
- Writes to CTRL:
  - A write that changes EN 0→1 loads COUNT ← LOAD (new LOAD if written the same cycle is not possible — separate register) and clears the prescaler counter.
  - A write of EN = 0 freezes COUNT and the prescaler.
- Writing LOAD while running does not alter COUNT until the next reload.
- Simultaneous expiry and a STATUS write-1-clear in the same cycle: set wins, EXPIRED stays 1.
- o_Irq = EXPIRED & IRQ_EN, registered.
- Reset values: all registers 0, FSM R_IDLE, o_AV_ReadData 0, o_AV_WaitRequest 0, o_Irq 0.
- Reset asserted mid-read: FSM returns to R_IDLE and all outputs are 0 immediately.

Test Plan:
- Reset, then read CTRL, LOAD, COUNT, PRESCALE and STATUS → each read: WaitRequest high for 1 cycle, then ReadData = 0; non-selected address → ReadData 0 and WaitRequest 0 throughout.
- LOAD = 3, PRESCALE = 0, CTRL = 0x5 (one-shot) → COUNT reads 3, 2, 1, 0 on consecutive cycles; EXPIRED = 1; o_Irq rises 1 cycle after EXPIRED; EN reads 0; COUNT holds 0.
- LOAD = 2, PRESCALE = 4, CTRL = 0x3 → COUNT decrements every 5 cycles; after 0 it reloads to 2; EXPIRED is set every 15 cycles.
- Byte-lane write of 0xAABBCCDD to LOAD with ByteEn = 4'b0101 → LOAD reads 0x00BB00DD; a write to COUNT is ignored.
- EXPIRED = 1, write STATUS = 1 → EXPIRED 0 and o_Irq 0; a write-1-clear in the same cycle as an expiry tick leaves EXPIRED = 1.
- Assert i_nRst low during the R_DATA cycle of a read → WaitRequest and ReadData are 0 at once; after release, CTRL = 0 and the timer is stopped.
